// File: rtl/reg_file_sb.sv
// Parametrised register file with hardwired-zero x0, write-to-read bypass and
// per-register pending-write (busy) scoreboard with flush.
module reg_file_sb #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NRD  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                RegWrite,
  input  logic [AW-1:0]       WriteAddr,
  input  logic [XLEN-1:0]     WriteData,
  input  logic                IssueValid,
  input  logic [AW-1:0]       IssueAddr,
  input  logic                Flush,
  input  logic [NRD*AW-1:0]   ReadAddr,
  output logic [NRD*XLEN-1:0] ReadData,
  output logic [NRD-1:0]      ReadBusy,
  output logic [AW:0]         BusyCount
);

  localparam int unsigned NREGS = 2 ** AW;

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      busy_count_q, busy_count_d;
  logic             wr_en;

  assign wr_en = RegWrite && (WriteAddr != '0);

  // Next state: array write, busy priority flush > issue > writeback, popcount.
  always_comb begin
    regs_d       = regs_q;
    busy_d       = busy_q;
    busy_count_d = '0;
    if (wr_en) regs_d[WriteAddr] = WriteData;
    for (int unsigned r = 1; r < NREGS; r++) begin
      if (Flush) begin
        busy_d[AW'(r)] = 1'b0;
      end else if (IssueValid && (IssueAddr == AW'(r))) begin
        busy_d[AW'(r)] = 1'b1;
      end else if (RegWrite && (WriteAddr == AW'(r))) begin
        busy_d[AW'(r)] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      busy_count_d = busy_count_d + (AW + 1)'(busy_d[AW'(r)]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < NREGS; r++) regs_q[r] <= '0;
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      regs_q       <= regs_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign BusyCount = busy_count_q;

  // Read ports; bypass is gated by reset so reads stay zero while it is held.
  always_comb begin
    logic [AW-1:0] a;
    logic          hit;
    ReadData = '0;
    ReadBusy = '0;
    a        = '0;
    hit      = 1'b0;
    for (int unsigned i = 0; i < NRD; i++) begin
      a   = ReadAddr[i*AW +: AW];
      hit = rst && RegWrite && (WriteAddr == a);
      if (a == '0) begin
        ReadData[i*XLEN +: XLEN] = '0;
      end else if (hit) begin
        ReadData[i*XLEN +: XLEN] = WriteData;
      end else begin
        ReadData[i*XLEN +: XLEN] = regs_q[a];
      end
      ReadBusy[i] = busy_q[a] && !hit;
    end
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with scoreboard for the pipelined RV32I core. It replaces the fixed 32x32, 2-read-port file with configurable width, depth and read-port count. It adds hardwired-zero register 0, write-to-read bypass and per-register busy (pending-write) tracking with flush. Decode reads operands and busy status from it, and writeback writes it.

## Interface
- XLEN, 32, data width in bits.
- AW, 5, register address width; depth NREGS = 2**AW.
- NRD, 2, number of read ports (1..4).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low; clears all registers and busy bits.
- RegWrite  in  1  writeback strobe.
- WriteAddr  in  AW  writeback destination.
- WriteData  in  XLEN  writeback value.
- IssueValid  in  1  an instruction with a destination register leaves decode.
- IssueAddr  in  AW  destination of the issuing instruction.
- Flush  in  1  pipeline flush; clears every busy bit.
- ReadAddr  in  NRD*AW  packed read addresses; port i is bits [i*AW +: AW].
- ReadData  out  NRD*XLEN  packed read data; port i is bits [i*XLEN +: XLEN].
- ReadBusy  out  NRD  bit i is 1 when port i's register has an outstanding write.
- BusyCount  out  AW+1  number of busy registers.

## Operation
- Storage: NREGS x XLEN array plus an NREGS-bit busy vector. Register 0 always reads 0, is never written and is never busy.
- Write: on a clock edge with RegWrite=1 and WriteAddr!=0, the register takes WriteData.
- Read (combinational), per port i with address a:
  - a==0 → 0.
  - Else, if RegWrite=1 and WriteAddr==a → WriteData (bypass).
  - Else → the stored value.
- Busy next-state, per register r!=0, in priority order:
  - Flush=1 → 0.
  - Else, IssueValid=1 and IssueAddr==r → 1. A new producer wins over a same-cycle writeback to r.
  - Else, RegWrite=1 and WriteAddr==r → 0.
  - Else → hold.
- ReadBusy[i] = busy[a] AND NOT (RegWrite=1 and WriteAddr==a). The value being written this cycle is bypassed, so it is not a hazard. A same-cycle issue does not affect ReadBusy until the next cycle.
- Flush does not block data writes: RegWrite in the flush cycle still updates the array.
- BusyCount = population count of the registered busy vector.
- Writeback to a register that is not busy is legal: data is written and busy stays 0.
- Issue to register 0 is ignored.

## Timing
- Reset (rst=0, asynchronous): all registers and busy bits are 0 immediately. Therefore ReadData=0, ReadBusy=0 and BusyCount=0.
- While rst=0:
  - bypass is suppressed, so ReadData stays 0;
  - RegWrite, IssueValid and Flush are ignored.
- Deassertion is synchronous to the next rising edge, and normal operation resumes from that edge.
- Read latency is 0 cycles (combinational from ReadAddr and the write port).
- Write latency: the stored value is visible through the array on the cycle after the edge, and through the bypass in the same cycle.
- Busy set or clear takes effect on ReadBusy and BusyCount one cycle after the edge.
- Maximum BusyCount is NREGS-1; the width AW+1 cannot overflow.
- Reset asserted mid-operation discards all in-flight busy state. Writebacks after reset do not set busy.

## Test plan
- Reset with a write pending: load x5=0xDEADBEEF, assert rst=0 mid-cycle → ReadData and ReadBusy are 0 immediately, BusyCount=0. After release, x5 reads 0.
- Write then read, including bypass: RegWrite, WriteAddr=3, WriteData=0x12345678, with ReadAddr port0=3 in the same cycle → port0=0x12345678 that cycle and the next. Write to x0 with 0xFFFFFFFF → x0 still reads 0.
- Scoreboard lifecycle: issue x7 → ReadBusy on x7 is 1 from the next cycle and BusyCount=1. Writeback to x7 three cycles later → ReadBusy=0 in the writeback cycle and BusyCount=0 the cycle after.
- Simultaneous issue and writeback to x9 while busy: data written, busy stays 1, BusyCount unchanged. Then writeback alone → busy clears.
- Flush: issue x1, x2 and x3 (BusyCount=3), then Flush with IssueValid to x4 and RegWrite to x2=0x55 in the same cycle → all busy 0, BusyCount=0, x2 reads 0x55.
- Parameter sweep with XLEN=64, AW=4, NRD=3: three ports read different registers (including one bypassed) in the same cycle → each returns the correct value. Register 15 writes and reads back correctly.
